pixel_chunk_packer: RTL
=======================

Name: pixel_chunk_packer

Overview:
- Sits between the depth-test/clear mux and the DDR write address/data FIFOs.
- Takes per-pixel 16-bit colour writes with a write strobe and merges pixels of the same 8-pixel chunk into one 128-bit word with 16 byte enables.
- Emits one AXI-stream-style chunk per touched chunk, which minimises DDR write transactions.
- Supports explicit flush (frame end) and idle-timeout flush.

Parameters:
HRES, 320, horizontal resolution in pixels
VRES, 180, vertical resolution in pixels
FLUSH_TIMEOUT, 16, idle cycles with a partially filled accumulator before forced flush (>=2)

Ports:
clk_in  input  1  system clock
rst_in  input  1  asynchronous active-high reset
valid_in  input  1  pixel beat valid
addr_in  input  27  linear pixel index (y*HRES+x)
data_in  input  16  pixel colour
strobe_in  input  1  1 = write this pixel; 0 = beat consumed, lane untouched (depth fail)
ready_out  output  1  pixel beat accepted when valid_in&&ready_out
flush_in  input  1  level; push out accumulator, block input while high
valid_out  output  1  chunk valid
ready_in  input  1  downstream (both FIFOs) ready
addr_out  output  27  chunk index = pixel index >> 3
data_out  output  128  lane L at bits [16L+15:16L]
strobe_out  output  16  byte enables; lane L -> bits [2L+1:2L]
last_out  output  1  addr_out == CHUNK_DEPTH-1
idle_out  output  1  accumulator empty and output register empty

Behaviour:
- Constants: DEPTH=HRES*VRES; CHUNK_DEPTH=DEPTH/8 (DEPTH multiple of 8). Chunk = addr_in[26:3]; lane = addr_in[2:0].
- Reset (async, any time incl. mid-chunk): acc and output register cleared and all partial data discarded. valid_out=0, data_out=0, strobe_out=0, addr_out=0, last_out=0, idle_out=1. Timeout counter=0.
- Storage: accumulator (acc_chunk, acc_data, acc_strb, acc_active) plus one output register (out_valid drives valid_out).
- Output handshake: an output transfer occurs when valid_out&&ready_in. While valid_out=1 and ready_in=0, addr_out/data_out/strobe_out/last_out hold stable.
- slot_free = !out_valid || ready_in.
- ready_out = slot_free && !flush_in. This is combinational.
- On accepted beat, in priority order:
  - addr_in>=DEPTH: beat consumed, dropped, no state change except timeout reset.
  - acc empty: acc_chunk<=chunk, acc_active<=1. Lane written if strobe_in.
  - Same chunk: lane merge. Lane data overwritten and strobe bits set if strobe_in. A repeated write to a lane is last-wins.
  - Different chunk: acc moves to the output register (out_valid<=1) if acc_strb!=0, else it is silently dropped. Acc restarts with the new beat in the same cycle, giving full throughput with ready_in=1.
- Zero-strobe rule: a chunk with acc_strb==0 is never emitted. This applies to chunk change, timeout and flush.
- Timeout: the counter increments each cycle acc_active with no accepted beat, and resets on an accepted beat. At count==FLUSH_TIMEOUT-1, when slot_free, acc moves to output (or is dropped if strobe 0), then acc_active<=0 and the counter is cleared. If not slot_free, the counter saturates and the move waits for slot_free.
- flush_in: input is blocked. When acc_active&&slot_free, acc moves as above. idle_out rises once both stages are empty. flush_in asserted while already idle has no effect.
- Latency: a chunk appears on valid_out the cycle after the beat that closes it (chunk change), or after timeout/flush, as above.
- Simultaneous output transfer and new move in the same cycle: the output register is reloaded with out_valid staying 1, so no bubble.
- last_out is registered with the output register.

Test Plan:
- Pixels addr 0..7, strobe 1, data 16'h1000+k, then addr 8 with ready_in=1 -> next cycle one chunk: addr_out=0, strobe_out=16'hFFFF, data_out lane k=16'h1000+k; no other output.
- addr 5 (strobe 1, data 16'hABCD), then addr 20 -> chunk addr_out=0, strobe_out=16'h0C00, data_out[95:80]=16'hABCD, all other lanes 0.
- addr 8..15 all strobe 0, then addr 40 -> no valid_out. addr 3 written twice (16'h1111, then 16'h2222) -> lane 3=16'h2222.
- Chunk pending, ready_in=0 for 5 cycles, new chunk arrives -> ready_out=0 for those cycles, data_out stable, no loss. ready_in=1 -> both chunks emitted in order.
- Single pixel addr 57599, then idle -> valid_out after FLUSH_TIMEOUT cycles: addr_out=7199, last_out=1, strobe_out=16'hC000.
- Partial chunk, flush_in=1 -> ready_out=0, chunk emitted, idle_out=1. Separately, rst_in mid-accumulation -> no output afterwards, idle_out=1 immediately.

Source files
------------

// File: rtl/pixel_chunk_packer.sv
// rtl/pixel_chunk_packer.sv - merges per-pixel colour writes into 8-pixel, 128-bit byte-enabled DDR chunks
module pixel_chunk_packer #(
    parameter int HRES          = 320,
    parameter int VRES          = 180,
    parameter int FLUSH_TIMEOUT = 16
) (
    input  logic         clk_in,
    input  logic         rst_in,
    input  logic         valid_in,
    input  logic [26:0]  addr_in,
    input  logic [15:0]  data_in,
    input  logic         strobe_in,
    output logic         ready_out,
    input  logic         flush_in,
    output logic         valid_out,
    input  logic         ready_in,
    output logic [26:0]  addr_out,
    output logic [127:0] data_out,
    output logic [15:0]  strobe_out,
    output logic         last_out,
    output logic         idle_out
);

    localparam int          DEPTH       = HRES * VRES;
    localparam int          CHUNK_DEPTH = DEPTH / 8;
    localparam int          TW          = $clog2(FLUSH_TIMEOUT);
    localparam logic [26:0] DEPTH_W     = 27'(DEPTH);
    localparam logic [23:0] LAST_CHUNK  = 24'(CHUNK_DEPTH - 1);
    localparam logic [TW-1:0] TMO_MAX   = TW'(FLUSH_TIMEOUT - 1);

    logic [23:0]   acc_chunk;
    logic [127:0]  acc_data;
    logic [15:0]   acc_strb;
    logic          acc_active;
    logic [TW-1:0] tmo_cnt;

    logic          out_valid;
    logic [23:0]   out_chunk;
    logic [127:0]  out_data;
    logic [15:0]   out_strb;
    logic          out_last;

    logic          slot_free;
    logic          accept;
    logic          in_range;
    logic          same_chunk;
    logic          tmo_hit;
    logic          beat_move;
    logic          idle_move;
    logic          load_out;
    logic [23:0]   beat_chunk;
    logic [2:0]    beat_lane;
    logic [127:0]  merge_data;
    logic [15:0]   merge_strb;

    always_comb begin
        slot_free  = !out_valid || ready_in;
        ready_out  = slot_free && !flush_in;
        accept     = valid_in && ready_out;
        in_range   = addr_in < DEPTH_W;
        beat_chunk = addr_in[26:3];
        beat_lane  = addr_in[2:0];
        same_chunk = acc_active && (beat_chunk == acc_chunk);
        tmo_hit    = tmo_cnt == TMO_MAX;
        beat_move  = accept && in_range && acc_active && !same_chunk;
        // Timeout and flush only close the accumulator when no beat is arriving.
        idle_move  = !accept && acc_active && slot_free && (flush_in || tmo_hit);
        // Chunks with no lane written are discarded rather than emitted.
        load_out   = (beat_move || idle_move) && (acc_strb != 16'h0000);
    end

    always_comb begin
        merge_data = same_chunk ? acc_data : '0;
        merge_strb = same_chunk ? acc_strb : '0;
        if (strobe_in) begin
            merge_data[{beat_lane, 4'b0000} +: 16] = data_in;
            merge_strb[{beat_lane, 1'b0} +: 2]     = 2'b11;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            acc_chunk  <= '0;
            acc_data   <= '0;
            acc_strb   <= '0;
            acc_active <= 1'b0;
            tmo_cnt    <= '0;
        end else if (accept && in_range) begin
            acc_chunk  <= beat_chunk;
            acc_data   <= merge_data;
            acc_strb   <= merge_strb;
            acc_active <= 1'b1;
            tmo_cnt    <= '0;
        end else if (accept) begin
            tmo_cnt    <= '0;
        end else if (idle_move) begin
            acc_data   <= '0;
            acc_strb   <= '0;
            acc_active <= 1'b0;
            tmo_cnt    <= '0;
        end else if (acc_active && !tmo_hit) begin
            tmo_cnt    <= tmo_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            out_valid <= 1'b0;
            out_chunk <= '0;
            out_data  <= '0;
            out_strb  <= '0;
            out_last  <= 1'b0;
        end else if (load_out) begin
            out_valid <= 1'b1;
            out_chunk <= acc_chunk;
            out_data  <= acc_data;
            out_strb  <= acc_strb;
            out_last  <= acc_chunk == LAST_CHUNK;
        end else if (ready_in) begin
            out_valid <= 1'b0;
        end
    end

    assign valid_out  = out_valid;
    assign addr_out   = {3'b000, out_chunk};
    assign data_out   = out_data;
    assign strobe_out = out_strb;
    assign last_out   = out_last;
    assign idle_out   = !acc_active && !out_valid;

endmodule
